// File: rtl/gpio_cmd_decoder.sv
// GPIO command decoder: registers the processor command word, decodes opcodes,
// drives DSP control, the RAM logger, RAM readback and BER snapshot readback.
//
// Ports:
//   clockdsp          DSP clock, all state changes on its rising edge
//   i_reset           synchronous active-low reset
//   i_gpio_word       command frame {opcode[31:24], enable[23], payload[22:0]}
//   i_log_full        logger reached its last address (one-cycle pulse)
//   i_ram_rdata       RAM read data for o_ram_raddr
//   i_ber_bits/errs   live PRBS checker counters
//   o_gpio_word       status / readback frame
//   o_dsp_rst         soft reset for the DSP chain (active high)
//   o_adapt_en        adaptive filter enable
//   o_log_run         logger write enable
//   o_log_sel         logger source select
//   o_ram_raddr       RAM read address
module gpio_cmd_decoder #(
    parameter int RAM_AW = 15,
    parameter int BER_W  = 32
) (
    input  logic              clockdsp,
    input  logic              i_reset,
    input  logic [31:0]       i_gpio_word,
    input  logic              i_log_full,
    input  logic [31:0]       i_ram_rdata,
    input  logic [BER_W-1:0]  i_ber_bits,
    input  logic [BER_W-1:0]  i_ber_errs,
    output logic [31:0]       o_gpio_word,
    output logic              o_dsp_rst,
    output logic              o_adapt_en,
    output logic              o_log_run,
    output logic [1:0]        o_log_sel,
    output logic [RAM_AW-1:0] o_ram_raddr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOG,
        ST_READ,
        ST_BER
    } state_e;

    localparam logic [7:0] OP_RST   = 8'h01;
    localparam logic [7:0] OP_ADAPT = 8'h02;
    localparam logic [7:0] OP_LOG   = 8'h03;
    localparam logic [7:0] OP_READ  = 8'h04;
    localparam logic [7:0] OP_SNAP  = 8'h05;
    localparam logic [7:0] OP_BSEL  = 8'h06;

    // Input register; it keeps sampling during reset so that a word that
    // was already present before reset is not mistaken for a new command.
    logic [31:0] word_q;

    always_ff @(posedge clockdsp) begin
        word_q <= i_gpio_word;
    end

    state_e             state_q, state_d;
    logic [31:0]        prev_q;
    logic               armed_q;
    logic               dsp_rst_q, dsp_rst_d;
    logic               adapt_en_q, adapt_en_d;
    logic               log_run_q, log_run_d;
    logic [1:0]         log_sel_q, log_sel_d;
    logic [RAM_AW-1:0]  raddr_q, raddr_d;
    logic [31:0]        gpio_word_q, gpio_word_d;
    logic               done_q, done_d;
    logic [BER_W-1:0]   snap_bits_q, snap_bits_d;
    logic [BER_W-1:0]   snap_errs_q, snap_errs_d;
    logic               ber_sel_q, ber_sel_d;

    logic [7:0] opcode;
    logic       accept;
    logic [3:0] sel_off;
    logic       start_ok;

    assign opcode = word_q[31:24];

    // armed_q masks the first cycle after reset, when prev_q is still zero
    // and a held word would otherwise look new.
    assign accept = armed_q && word_q[23] && (word_q != prev_q);

    always_comb begin
        state_d     = state_q;
        dsp_rst_d   = dsp_rst_q;
        adapt_en_d  = adapt_en_q;
        log_run_d   = log_run_q;
        log_sel_d   = log_sel_q;
        raddr_d     = raddr_q;
        done_d      = done_q;
        snap_bits_d = snap_bits_q;
        snap_errs_d = snap_errs_q;
        ber_sel_d   = ber_sel_q;
        gpio_word_d = gpio_word_q;
        sel_off     = word_q[3:0] - 4'd9;
        start_ok    = (word_q[3:0] >= 4'h9) && (word_q[3:0] <= 4'hC);

        if (accept) begin
            unique case (opcode)
                OP_RST: begin
                    dsp_rst_d = word_q[0];
                end
                OP_ADAPT: begin
                    adapt_en_d = word_q[0];
                end
                OP_LOG: begin
                    if (word_q[3:0] == 4'h0) begin
                        state_d   = ST_IDLE;
                        log_run_d = 1'b0;
                    end else if (start_ok && state_q == ST_IDLE) begin
                        state_d   = ST_LOG;
                        log_run_d = 1'b1;
                        log_sel_d = sel_off[1:0];
                        done_d    = 1'b0;
                    end
                end
                OP_READ: begin
                    if (state_q != ST_LOG) begin
                        if (word_q[16]) begin
                            state_d = ST_READ;
                            raddr_d = word_q[RAM_AW-1:0];
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                OP_SNAP: begin
                    if (word_q[0]) begin
                        snap_bits_d = i_ber_bits;
                        snap_errs_d = i_ber_errs;
                    end
                end
                OP_BSEL: begin
                    if (state_q != ST_LOG) begin
                        state_d   = ST_BER;
                        ber_sel_d = word_q[0];
                    end
                end
                default: begin
                end
            endcase
        end

        // Logger completion wins over a same-cycle abort: both end in IDLE,
        // but only completion marks the log as done.
        if (state_q == ST_LOG && i_log_full) begin
            state_d   = ST_IDLE;
            log_run_d = 1'b0;
            done_d    = 1'b1;
        end

        case (state_d)
            ST_READ: gpio_word_d = i_ram_rdata;
            ST_BER: begin
                if (ber_sel_d) begin
                    gpio_word_d = 32'(snap_errs_d);
                end else begin
                    gpio_word_d = 32'(snap_bits_d);
                end
            end
            default: gpio_word_d = {30'h0, done_d, log_run_d};
        endcase
    end

    always_ff @(posedge clockdsp) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            armed_q     <= 1'b0;
            dsp_rst_q   <= 1'b1;
            adapt_en_q  <= 1'b0;
            log_run_q   <= 1'b0;
            log_sel_q   <= 2'd0;
            raddr_q     <= '0;
            gpio_word_q <= '0;
            done_q      <= 1'b0;
            snap_bits_q <= '0;
            snap_errs_q <= '0;
            ber_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= word_q;
            armed_q     <= 1'b1;
            dsp_rst_q   <= dsp_rst_d;
            adapt_en_q  <= adapt_en_d;
            log_run_q   <= log_run_d;
            log_sel_q   <= log_sel_d;
            raddr_q     <= raddr_d;
            gpio_word_q <= gpio_word_d;
            done_q      <= done_d;
            snap_bits_q <= snap_bits_d;
            snap_errs_q <= snap_errs_d;
            ber_sel_q   <= ber_sel_d;
        end
    end

    assign o_gpio_word = gpio_word_q;
    assign o_dsp_rst   = dsp_rst_q;
    assign o_adapt_en  = adapt_en_q;
    assign o_log_run   = log_run_q;
    assign o_log_sel   = log_sel_q;
    assign o_ram_raddr = raddr_q;

endmodule

// File: tb/tb_gpio_cmd_decoder.sv
// Self-checking bench for gpio_cmd_decoder: directed scenarios with literal
// expectations plus randomized commands against a behavioural model.
module tb_gpio_cmd_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] gpio_in;
    logic        log_full;
    logic [31:0] ram_rdata;
    logic [31:0] ber_bits;
    logic [31:0] ber_errs;
    logic [31:0] gpio_out;
    logic        dsp_rst;
    logic        adapt_en;
    logic        log_run;
    logic [1:0]  log_sel;
    logic [14:0] ram_raddr;

    gpio_cmd_decoder #(.RAM_AW(15), .BER_W(32)) dut (
        .clockdsp    (clk),
        .i_reset     (rst_n),
        .i_gpio_word (gpio_in),
        .i_log_full  (log_full),
        .i_ram_rdata (ram_rdata),
        .i_ber_bits  (ber_bits),
        .i_ber_errs  (ber_errs),
        .o_gpio_word (gpio_out),
        .o_dsp_rst   (dsp_rst),
        .o_adapt_en  (adapt_en),
        .o_log_run   (log_run),
        .o_log_sel   (log_sel),
        .o_ram_raddr (ram_raddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ram_fn(input logic [14:0] a);
        if (a < 15'd4) return 32'(a);
        return {17'h0, a} * 32'h9E37 + 32'h1;
    endfunction

    assign ram_rdata = ram_fn(ram_raddr);

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: modes as plain integers.
    localparam int MI = 0, ML = 1, MR = 2, MB = 3;
    int          m_mode;
    logic        m_rst, m_adapt, m_run, m_done, m_bsel, m_armed;
    logic [1:0]  m_sel;
    logic [14:0] m_raddr;
    logic [31:0] m_gpio, m_sb, m_se, m_prev, m_wreg;
    bit          chk_en = 0;

    task automatic apply_cmd(input logic [31:0] w);
        logic [7:0]  op;
        logic [22:0] p;
        op = w[31:24];
        p  = w[22:0];
        if (op == 8'h01) m_rst = p[0];
        else if (op == 8'h02) m_adapt = p[0];
        else if (op == 8'h03) begin
            if (p[3:0] == 4'h0) begin
                m_mode = MI;
                m_run  = 1'b0;
            end else if (m_mode == MI && p[3:0] >= 4'h9 && p[3:0] <= 4'hC) begin
                m_mode = ML;
                m_run  = 1'b1;
                m_sel  = 2'(int'(p[3:0]) - 9);
                m_done = 1'b0;
            end
        end else if (op == 8'h04) begin
            if (m_mode != ML) begin
                if (p[16]) begin
                    m_mode  = MR;
                    m_raddr = p[14:0];
                end else m_mode = MI;
            end
        end else if (op == 8'h05) begin
            if (p[0]) begin
                m_sb = ber_bits;
                m_se = ber_errs;
            end
        end else if (op == 8'h06) begin
            if (m_mode != ML) begin
                m_mode = MB;
                m_bsel = p[0];
            end
        end
    endtask

    always @(posedge clk) begin
        int          old_mode;
        logic [14:0] old_raddr;
        if (!rst_n) begin
            m_mode = MI; m_rst = 1'b1; m_adapt = 1'b0; m_run = 1'b0;
            m_sel = 2'd0; m_raddr = '0; m_gpio = '0; m_done = 1'b0;
            m_sb = '0; m_se = '0; m_bsel = 1'b0; m_prev = '0;
            m_armed = 1'b0;
        end else begin
            old_mode  = m_mode;
            old_raddr = m_raddr;
            if (m_armed && m_wreg[23] && m_wreg != m_prev) apply_cmd(m_wreg);
            if (old_mode == ML && log_full) begin
                m_mode = MI;
                m_run  = 1'b0;
                m_done = 1'b1;
            end
            if (m_mode == MR) m_gpio = ram_fn(old_raddr);
            else if (m_mode == MB) m_gpio = m_bsel ? m_se : m_sb;
            else m_gpio = {30'h0, m_done, m_run};
            m_prev  = m_wreg;
            m_armed = 1'b1;
        end
        m_wreg = gpio_in;
        chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_dsp_rst", 32'(dsp_rst), 32'(m_rst));
            chk("m_adapt_en", 32'(adapt_en), 32'(m_adapt));
            chk("m_log_run", 32'(log_run), 32'(m_run));
            chk("m_log_sel", 32'(log_sel), 32'(m_sel));
            chk("m_raddr", 32'(ram_raddr), 32'(m_raddr));
            chk("m_gpio_word", gpio_out, m_gpio);
        end
    end

    // Called at a negedge: registered at the next edge, effect one edge later.
    task automatic drive(input logic [31:0] w);
        gpio_in = w;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] w;
        logic [22:0] p;
        logic [7:0]  op;
        int          rst_hold;
        logic        prev_full;
        rst_n = 1'b0; gpio_in = '0; log_full = 1'b0;
        ber_bits = '0; ber_errs = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dsp", 32'(dsp_rst), 32'd1);
        chk("rst_adapt", 32'(adapt_en), 32'd0);
        chk("rst_run", 32'(log_run), 32'd0);
        chk("rst_sel", 32'(log_sel), 32'd0);
        chk("rst_raddr", 32'(ram_raddr), 32'd0);
        chk("rst_gpio", gpio_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        drive(32'h01800001);
        chk("dsp_set", 32'(dsp_rst), 32'd1);
        drive(32'h01800000);
        chk("dsp_clr", 32'(dsp_rst), 32'd0);
        drive(32'h02800001);
        chk("adapt_set", 32'(adapt_en), 32'd1);
        drive(32'h02000000);
        chk("adapt_en0_ignored", 32'(adapt_en), 32'd1);

        drive(32'h0380000A);
        chk("log_run", 32'(log_run), 32'd1);
        chk("log_sel", 32'(log_sel), 32'd1);
        chk("log_gpio", gpio_out, 32'h1);
        log_full = 1'b1;
        @(posedge clk);
        @(negedge clk);
        log_full = 1'b0;
        chk("full_run", 32'(log_run), 32'd0);
        chk("full_gpio", gpio_out, 32'h2);

        for (int i = 0; i < 7; i++) begin
            if (i < 4) gpio_in = 32'h04810000 + 32'(i);
            if (i >= 3) chk("read_data", gpio_out, 32'(i - 3));
            @(negedge clk);
        end

        ber_bits = 32'd1000;
        ber_errs = 32'd3;
        drive(32'h05800001);
        drive(32'h06800001);
        chk("ber_errs", gpio_out, 32'd3);
        drive(32'h06800000);
        chk("ber_bits", gpio_out, 32'd1000);

        drive(32'h03800000);
        chk("abort_done", gpio_out, 32'h2);
        drive(32'h0380000C);
        chk("log2_run", 32'(log_run), 32'd1);
        chk("log2_sel", 32'(log_sel), 32'd3);
        chk("log2_done_clr", gpio_out, 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rlog_run", 32'(log_run), 32'd0);
        chk("rlog_sel", 32'(log_sel), 32'd0);
        chk("rlog_dsp", 32'(dsp_rst), 32'd1);
        chk("rlog_adapt", 32'(adapt_en), 32'd0);
        chk("rlog_gpio", gpio_out, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_reaccept", 32'(log_run), 32'd0);

        rst_hold = 0;
        prev_full = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                p = 23'($urandom);
                case ($urandom_range(0, 7))
                    0: op = 8'h01;
                    1: op = 8'h02;
                    2, 3: begin
                        op = 8'h03;
                        case ($urandom_range(0, 6))
                            0: p[3:0] = 4'h0;
                            1: p[3:0] = 4'h9;
                            2: p[3:0] = 4'hA;
                            3: p[3:0] = 4'hB;
                            4: p[3:0] = 4'hC;
                            5: p[3:0] = 4'h5;
                            default: p[3:0] = 4'hF;
                        endcase
                    end
                    4: begin
                        op = 8'h04;
                        p[16] = ($urandom_range(0, 3) != 0);
                        if ($urandom_range(0, 1) == 0) p[14:0] = 15'($urandom_range(0, 7));
                    end
                    5: op = 8'h05;
                    6: op = 8'h06;
                    default: op = 8'($urandom_range(7, 255));
                endcase
                w = {op, ($urandom_range(0, 4) != 0), p};
                gpio_in = w;
            end
            log_full = !prev_full && ($urandom_range(0, 15) == 0);
            prev_full = log_full;
            ber_bits = $urandom;
            ber_errs = $urandom;
            if (rst_hold > 0) rst_hold--;
            else if ($urandom_range(0, 399) == 0) rst_hold = $urandom_range(1, 2);
            rst_n = (rst_hold == 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        log_full = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
